// File: rtl/scaler_conv.sv
// Separable KERNEL_MAX x KERNEL_MAX weighted-sum stage of the scaler stream: a five-stage
// multiply/accumulate pipeline with rounding and clamping, framed by a per-line connect FSM.
module scaler_conv #(
    parameter int PIXEL_BITWIDTH       = 8,
    parameter int KERNEL_MAX           = 4,
    parameter int KERNEL_COEF_BITWIDTH = 8,
    parameter int IMG_H_BITWIDTH       = 12,
    parameter int IMG_V_BITWIDTH       = 12
) (
    input  logic                                           core_clk,
    input  logic                                           core_rst_n,
    input  logic [IMG_H_BITWIDTH-1:0]                      core_arg_img_des_h,
    input  logic [IMG_V_BITWIDTH-1:0]                      core_arg_img_des_v,
    input  logic                                           core_start,
    output logic                                           s_axis_connect_ready,
    input  logic                                           s_axis_connect_valid,
    input  logic                                           s_axis_scaler_valid,
    input  logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0] s_axis_scaler_pixel,
    input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]     s_axis_scaler_coef_h,
    input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]     s_axis_scaler_coef_v,
    input  logic                                           s_axis_scaler_done,
    output logic                                           m_axis_tvalid,
    output logic [PIXEL_BITWIDTH-1:0]                      m_axis_tdata,
    output logic                                           m_axis_tuser,
    output logic                                           m_axis_tlast,
    output logic                                           frame_done,
    output logic                                           busy,
    output logic                                           err_overrun,
    output logic                                           err_underrun
);

    localparam int NPIX = KERNEL_MAX * KERNEL_MAX;
    localparam int WB   = 2 * KERNEL_COEF_BITWIDTH;          // coefficient product width
    localparam int PB   = WB + PIXEL_BITWIDTH + 1;           // weighted pixel width
    localparam int QB   = PB + $clog2(KERNEL_MAX);           // row partial sum width
    localparam int SB   = QB + $clog2(KERNEL_MAX);           // full sum width
    localparam int FRAC = 2 * (KERNEL_COEF_BITWIDTH - 2);    // Q6 x Q6 fraction bits
    localparam logic signed [SB-1:0] ROUND_C = SB'(2 ** (FRAC - 1));
    localparam logic signed [SB-1:0] PIX_MAX = SB'((2 ** PIXEL_BITWIDTH) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONNECT,
        ST_LINE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [IMG_H_BITWIDTH-1:0] des_h_q, col_cnt, col_after;
    logic [IMG_V_BITWIDTH-1:0] des_v_q, line_cnt, line_inc;
    logic                      start_ok, line_start, accept, overrun_set, underrun_set;
    logic                      line_step, pipe_busy;
    logic [3:0]                v_pipe, u_pipe, l_pipe;

    assign start_ok     = (state == ST_IDLE) && core_start;
    assign line_start   = (state == ST_CONNECT) && s_axis_connect_ready && s_axis_connect_valid;
    assign accept       = (state == ST_LINE) && s_axis_scaler_valid && (col_cnt < des_h_q);
    assign overrun_set  = (state == ST_LINE) && s_axis_scaler_valid && !(col_cnt < des_h_q);
    assign col_after    = col_cnt + IMG_H_BITWIDTH'(accept);
    assign underrun_set = (state == ST_LINE) && s_axis_scaler_done && (col_after < des_h_q);
    assign line_inc     = line_cnt + IMG_V_BITWIDTH'(1);
    assign pipe_busy    = (|v_pipe) || m_axis_tvalid;

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_next = state;
        line_step  = 1'b0;
        case (state)
            ST_IDLE:    if (core_start) state_next = ST_CONNECT;
            ST_CONNECT: if (line_start) state_next = ST_LINE;
            ST_LINE:    if (s_axis_scaler_done) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    line_step  = 1'b1;
                    state_next = (line_inc == des_v_q) ? ST_DONE : ST_CONNECT;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking (<=) for all registers so each one samples pre-edge values.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state                <= ST_IDLE;
            s_axis_connect_ready <= 1'b0;
            busy                 <= 1'b0;
            frame_done           <= 1'b0;
            des_h_q              <= '0;
            des_v_q              <= '0;
            col_cnt              <= '0;
            line_cnt             <= '0;
            err_overrun          <= 1'b0;
            err_underrun         <= 1'b0;
        end else begin
            state                <= state_next;
            s_axis_connect_ready <= (state_next == ST_CONNECT);
            busy                 <= (state_next == ST_CONNECT) || (state_next == ST_LINE) ||
                                    (state_next == ST_DRAIN);
            frame_done           <= (state_next == ST_DONE);
            if (start_ok) begin
                des_h_q      <= core_arg_img_des_h;
                des_v_q      <= core_arg_img_des_v;
                line_cnt     <= '0;
                err_overrun  <= 1'b0;
                err_underrun <= 1'b0;
            end else begin
                if (overrun_set)  err_overrun  <= 1'b1;
                if (underrun_set) err_underrun <= 1'b1;
                if (line_step)    line_cnt     <= line_inc;
            end
            if (line_start)  col_cnt <= '0;
            else if (accept) col_cnt <= col_after;
        end
    end

    // Control pipeline: valid, start-of-frame and end-of-line flags ride alongside the data.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            v_pipe        <= '0;
            u_pipe        <= '0;
            l_pipe        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            v_pipe        <= {v_pipe[2:0], accept};
            u_pipe        <= {u_pipe[2:0], accept && (col_cnt == '0) && (line_cnt == '0)};
            l_pipe        <= {l_pipe[2:0], accept && (col_cnt == des_h_q - IMG_H_BITWIDTH'(1))};
            m_axis_tvalid <= v_pipe[3];
            m_axis_tuser  <= v_pipe[3] && u_pipe[3];
            m_axis_tlast  <= v_pipe[3] && l_pipe[3];
        end
    end

    logic signed [WB-1:0]       s1_w   [NPIX];
    logic [PIXEL_BITWIDTH-1:0]  s1_pix [NPIX];
    logic signed [PB-1:0]       s2_p   [NPIX];
    logic signed [QB-1:0]       s3_part_c [KERNEL_MAX];
    logic signed [QB-1:0]       s3_part   [KERNEL_MAX];
    logic signed [SB-1:0]       s4_sum_c, s4_sum, rnd, shifted;
    logic [PIXEL_BITWIDTH-1:0]  pix_c;

    // NOTE: data stages carry no reset; only the valid pipeline above decides what is live.
    always_ff @(posedge core_clk) begin
        for (int r = 0; r < KERNEL_MAX; r++) begin
            for (int c = 0; c < KERNEL_MAX; c++) begin
                if (accept) begin
                    s1_w[r*KERNEL_MAX+c] <=
                        WB'($signed(s_axis_scaler_coef_v[r*KERNEL_COEF_BITWIDTH +: KERNEL_COEF_BITWIDTH])) *
                        WB'($signed(s_axis_scaler_coef_h[c*KERNEL_COEF_BITWIDTH +: KERNEL_COEF_BITWIDTH]));
                    s1_pix[r*KERNEL_MAX+c] <=
                        s_axis_scaler_pixel[(r*KERNEL_MAX+c)*PIXEL_BITWIDTH +: PIXEL_BITWIDTH];
                end
            end
        end
        for (int i = 0; i < NPIX; i++) begin
            if (v_pipe[0]) s2_p[i] <= PB'(s1_w[i]) * PB'($signed({1'b0, s1_pix[i]}));
        end
        for (int r = 0; r < KERNEL_MAX; r++) begin
            if (v_pipe[1]) s3_part[r] <= s3_part_c[r];
        end
        if (v_pipe[2]) s4_sum <= s4_sum_c;
    end

    always_comb begin
        s4_sum_c = '0;
        for (int r = 0; r < KERNEL_MAX; r++) begin
            s3_part_c[r] = '0;
            for (int c = 0; c < KERNEL_MAX; c++) begin
                s3_part_c[r] = s3_part_c[r] + QB'(s2_p[r*KERNEL_MAX+c]);
            end
            s4_sum_c = s4_sum_c + SB'(s3_part[r]);
        end
    end

    // Round half up, drop the Q12 fraction, then clamp into the unsigned pixel range.
    always_comb begin
        rnd     = s4_sum + ROUND_C;
        shifted = rnd >>> FRAC;
        if (shifted[SB-1])          pix_c = '0;
        else if (shifted > PIX_MAX) pix_c = '1;
        else                        pix_c = shifted[PIXEL_BITWIDTH-1:0];
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n)    m_axis_tdata <= '0;
        else if (v_pipe[3]) m_axis_tdata <= pix_c;
    end

endmodule

// File: tb/tb_scaler_conv.sv
// Scoreboard bench for scaler_conv: expected beats are queued when windows are driven and
// compared, together with their arrival cycle, when the DUT emits them.
module tb_scaler_conv;

    logic         core_clk = 1'b0;
    logic         core_rst_n = 1'b0;
    logic [11:0]  core_arg_img_des_h = '0;
    logic [11:0]  core_arg_img_des_v = '0;
    logic         core_start = 1'b0;
    logic         s_axis_connect_ready;
    logic         s_axis_connect_valid = 1'b0;
    logic         s_axis_scaler_valid = 1'b0;
    logic [127:0] s_axis_scaler_pixel = '0;
    logic [31:0]  s_axis_scaler_coef_h = '0;
    logic [31:0]  s_axis_scaler_coef_v = '0;
    logic         s_axis_scaler_done = 1'b0;
    logic         m_axis_tvalid;
    logic [7:0]   m_axis_tdata;
    logic         m_axis_tuser;
    logic         m_axis_tlast;
    logic         frame_done;
    logic         busy;
    logic         err_overrun;
    logic         err_underrun;

    scaler_conv dut (
        .core_clk             (core_clk),
        .core_rst_n           (core_rst_n),
        .core_arg_img_des_h   (core_arg_img_des_h),
        .core_arg_img_des_v   (core_arg_img_des_v),
        .core_start           (core_start),
        .s_axis_connect_ready (s_axis_connect_ready),
        .s_axis_connect_valid (s_axis_connect_valid),
        .s_axis_scaler_valid  (s_axis_scaler_valid),
        .s_axis_scaler_pixel  (s_axis_scaler_pixel),
        .s_axis_scaler_coef_h (s_axis_scaler_coef_h),
        .s_axis_scaler_coef_v (s_axis_scaler_coef_v),
        .s_axis_scaler_done   (s_axis_scaler_done),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tuser         (m_axis_tuser),
        .m_axis_tlast         (m_axis_tlast),
        .frame_done           (frame_done),
        .busy                 (busy),
        .err_overrun          (err_overrun),
        .err_underrun         (err_underrun)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [7:0] data;
        logic       user;
        logic       last;
        int         cyc;
    } beat_t;

    beat_t sb[$];
    int    n_pass = 0;
    int    n_checks = 0;
    int    cyc = 0;
    int    beats = 0;
    int    fd_cnt = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(posedge core_clk) cyc++;

    always @(negedge core_clk) begin
        if (frame_done) fd_cnt++;
        if (m_axis_tvalid) begin
            beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("tdata", m_axis_tdata, e.data);
                check("tuser", m_axis_tuser, e.user);
                check("tlast", m_axis_tlast, e.last);
                check("latency", cyc, e.cyc);
            end
        end
    end

    // Independent reference: full double sum, round half up at 2^11, shift 12, clamp.
    function automatic logic [7:0] model(logic [127:0] px, logic [31:0] h, logic [31:0] v);
        longint acc = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int a, b, p;
                a = $signed(v[r*8 +: 8]);
                b = $signed(h[c*8 +: 8]);
                p = px[(r*4+c)*8 +: 8];
                acc += longint'(a * b * p);
            end
        end
        acc = (acc + 2048) >>> 12;
        if (acc < 0)   return 8'd0;
        if (acc > 255) return 8'd255;
        return 8'(acc);
    endfunction

    function automatic logic [31:0] pack4(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [127:0] win(int fill, int r, int c, int val);
        logic [127:0] px;
        for (int i = 0; i < 16; i++) px[i*8 +: 8] = 8'(fill);
        px[(r*4+c)*8 +: 8] = 8'(val);
        return px;
    endfunction

    // Drives one window for one cycle (from a negedge); exp < 0 selects the reference model.
    task automatic send(logic [127:0] px, logic [31:0] h, logic [31:0] v, logic dn,
                        int idx, int line, int dh, int exp);
        beat_t b;
        s_axis_scaler_valid  = 1'b1;
        s_axis_scaler_pixel  = px;
        s_axis_scaler_coef_h = h;
        s_axis_scaler_coef_v = v;
        s_axis_scaler_done   = dn;
        if (idx < dh) begin
            b.data = (exp < 0) ? model(px, h, v) : 8'(exp);
            b.user = (idx == 0) && (line == 0);
            b.last = (idx == dh - 1);
            b.cyc  = cyc + 5;
            sb.push_back(b);
        end
        @(negedge core_clk);
        s_axis_scaler_valid = 1'b0;
        s_axis_scaler_done  = 1'b0;
    endtask

    task automatic send_rand(logic dn, int idx, int line, int dh);
        logic [127:0] px;
        px = {$urandom, $urandom, $urandom, $urandom};
        send(px,
             pack4(int'($urandom_range(0, 34)) - 10, int'($urandom_range(0, 34)) - 10,
                   int'($urandom_range(0, 34)) - 10, int'($urandom_range(0, 34)) - 10),
             pack4(int'($urandom_range(0, 34)) - 10, int'($urandom_range(0, 34)) - 10,
                   int'($urandom_range(0, 34)) - 10, int'($urandom_range(0, 34)) - 10),
             dn, idx, line, dh, -1);
    endtask

    task automatic start_frame(int h, int v);
        core_arg_img_des_h = 12'(h);
        core_arg_img_des_v = 12'(v);
        core_start = 1'b1;
        @(negedge core_clk);
        core_start = 1'b0;
    endtask

    task automatic do_connect();
        int t = 0;
        while (!s_axis_connect_ready && t < 50) begin
            @(negedge core_clk);
            t++;
        end
        check("connect_ready", s_axis_connect_ready, 1);
        s_axis_connect_valid = 1'b1;
        @(negedge core_clk);
        s_axis_connect_valid = 1'b0;
        check("ready_drop", s_axis_connect_ready, 0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!frame_done && t < 100) begin
            @(negedge core_clk);
            t++;
        end
        check("frame_done", frame_done, 1);
        check("busy_at_done", busy, 0);
        @(negedge core_clk);
        check("done_pulse", frame_done, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0, f0;
        logic [31:0] id;

        repeat (2) @(negedge core_clk);
        check("reset_outs", {s_axis_connect_ready, m_axis_tvalid, m_axis_tdata, m_axis_tuser,
                             m_axis_tlast, frame_done, busy, err_overrun, err_underrun}, 0);
        core_rst_n = 1'b1;

        // Connect offered with no frame running: ready must stay low.
        s_axis_connect_valid = 1'b1;
        repeat (5) @(negedge core_clk);
        check("ready_idle", s_axis_connect_ready, 0);
        check("busy_idle", busy, 0);

        // Directed arithmetic line; connect valid already high so the handshake is immediate.
        start_frame(6, 1);
        check("ready_after_start", s_axis_connect_ready, 1);
        check("busy_after_start", busy, 1);
        @(negedge core_clk);
        check("ready_after_hs", s_axis_connect_ready, 0);
        s_axis_connect_valid = 1'b0;
        id = pack4(0, 64, 0, 0);
        send(win(255, 1, 1, 200), id, id, 1'b0, 0, 0, 6, 200);
        send(win(255, 0, 0, 50), pack4(-64, 0, 0, 0), pack4(64, 0, 0, 0), 1'b0, 1, 0, 6, 0);
        send(win(255, 0, 0, 255), pack4(127, 0, 0, 0), pack4(127, 0, 0, 0), 1'b0, 2, 0, 6, 255);
        send(win(0, 0, 0, 128), pack4(1, 0, 0, 0), pack4(32, 0, 0, 0), 1'b0, 3, 0, 6, 1);
        send(win(0, 0, 0, 128), pack4(1, 0, 0, 0), pack4(16, 0, 0, 0), 1'b0, 4, 0, 6, 1);
        send(win(0, 0, 0, 1), pack4(89, 0, 0, 0), pack4(23, 0, 0, 0), 1'b1, 5, 0, 6, 0);
        wait_done();
        check("no_errs", {err_overrun, err_underrun}, 0);

        // Two-line frame, back-to-back random windows.
        b0 = beats;
        start_frame(4, 2);
        for (int l = 0; l < 2; l++) begin
            do_connect();
            for (int i = 0; i < 4; i++) send_rand(i == 3, i, l, 4);
        end
        wait_done();
        check("frame_beats", beats - b0, 8);

        // Overrun line then underrun line.
        start_frame(3, 2);
        do_connect();
        for (int i = 0; i < 5; i++) send_rand(i == 4, i, 0, 3);
        check("err_overrun", err_overrun, 1);
        check("no_underrun_yet", err_underrun, 0);
        do_connect();
        for (int i = 0; i < 2; i++) send_rand(1'b0, i, 1, 3);
        s_axis_scaler_done = 1'b1;
        @(negedge core_clk);
        s_axis_scaler_done = 1'b0;
        check("err_underrun", err_underrun, 1);
        wait_done();

        // New start clears sticky errors.
        start_frame(8, 1);
        check("errs_cleared", {err_overrun, err_underrun}, 0);
        do_connect();
        for (int i = 0; i < 3; i++) send_rand(1'b0, i, 0, 8);

        // Reset with three windows in flight.
        sb.delete();
        b0 = beats;
        f0 = fd_cnt;
        #1 core_rst_n = 1'b0;
        #1 check("rst_mid_outs", {s_axis_connect_ready, m_axis_tvalid, m_axis_tdata, m_axis_tuser,
                                  m_axis_tlast, frame_done, busy, err_overrun, err_underrun}, 0);
        repeat (2) @(negedge core_clk);
        core_rst_n = 1'b1;
        repeat (20) @(negedge core_clk);
        check("no_beats_after_rst", beats - b0, 0);
        check("no_done_after_rst", fd_cnt - f0, 0);

        // Clean frame after reset.
        start_frame(2, 1);
        do_connect();
        for (int i = 0; i < 2; i++) send_rand(i == 1, i, 0, 2);
        wait_done();
        check("post_rst_errs", {err_overrun, err_underrun}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
